// File: rtl/simd_regfile_if.sv
// Bundled write, dual-read and clear-control signals for simd_regfile.
// The master drives the requests; the slave (the register file) returns read data, rd_valid and busy.
interface simd_regfile_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int AW     = 4
);
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [LANES-1:0]        wr_mask;
    logic [LANES*LANE_W-1:0] wr_data;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr1;
    logic [AW-1:0]           rd_addr2;
    logic [LANES*LANE_W-1:0] rd_data1;
    logic [LANES*LANE_W-1:0] rd_data2;
    logic                    rd_valid;
    logic                    clr_req;
    logic                    busy;

    modport master (
        output wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr1, rd_addr2, clr_req,
        input  rd_data1, rd_data2, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr1, rd_addr2, clr_req,
        output rd_data1, rd_data2, rd_valid, busy
    );
endinterface

// File: rtl/simd_regfile.sv
// SIMD register file: one lane-masked write port, two registered read ports, sequential clear.
// Define SIMD_REGFILE_BYPASS_EN to forward a same-cycle write into reads of the same address.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting reads, writes and clear requests
// ST_CLEAR | zeroing one entry per cycle at clr_ptr; all requests ignored
module simd_regfile #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    simd_regfile_if.slave rf
);
    localparam int DW = LANES * LANE_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_val1;
    logic [DW-1:0] rd_val2;
    logic          idle;
    logic          wr_ok;
    logic          rd_ok;

    assign idle    = (state == ST_IDLE);
    assign rf.busy = (state == ST_CLEAR);
    // clr_req wins over a same-cycle read or write; those requests are dropped
    assign wr_ok   = idle && rf.wr_en && !rf.clr_req && (int'(rf.wr_addr) < DEPTH);
    assign rd_ok   = idle && rf.rd_en && !rf.clr_req;

    always_comb begin
        rd_val1 = '0;
        rd_val2 = '0;
        if (int'(rf.rd_addr1) < DEPTH) rd_val1 = mem[rf.rd_addr1];
        if (int'(rf.rd_addr2) < DEPTH) rd_val2 = mem[rf.rd_addr2];
`ifdef SIMD_REGFILE_BYPASS_EN
        for (int i = 0; i < LANES; i++) begin
            if (wr_ok && rf.wr_mask[i] && (rf.wr_addr == rf.rd_addr1))
                rd_val1[i*LANE_W +: LANE_W] = rf.wr_data[i*LANE_W +: LANE_W];
            if (wr_ok && rf.wr_mask[i] && (rf.wr_addr == rf.rd_addr2))
                rd_val2[i*LANE_W +: LANE_W] = rf.wr_data[i*LANE_W +: LANE_W];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rf.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(DEPTH - 1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LANES; i++)
                if (rf.wr_mask[i])
                    mem[rf.wr_addr][i*LANE_W +: LANE_W] <= rf.wr_data[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf.rd_data1 <= '0;
            rf.rd_data2 <= '0;
            rf.rd_valid <= 1'b0;
        end else begin
            rf.rd_valid <= rd_ok;
            if (rd_ok) begin
                rf.rd_data1 <= rd_val1;
                rf.rd_data2 <= rd_val2;
            end
        end
    end
endmodule
